// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller for the CPU's external interrupt line.
// It detects rising edges on the sources and latches them as pending. The
// lowest-index source that is both pending and enabled is dispatched through
// a request/acknowledge/end-of-interrupt handshake, with its handler vector
// presented alongside.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous, active-high reset
//   src_i      raw interrupt sources (a rising edge is one event)
//   mask_we_i  mask register write strobe
//   mask_wd_i  mask write data (1 = source enabled)
//   mask_o     current mask register
//   pending_o  latched events that have not yet been acknowledged
//   irq_o      interrupt request to the CPU
//   ack_i      CPU accepts the request (single-cycle pulse)
//   eoi_i      CPU has finished the handler (single-cycle pulse)
//   busy_o     a handler is in progress
//   id_o       index of the dispatched source
//   vec_o      VEC_BASE + id*VEC_STRIDE
//
// States:
//   IDLE    | nothing dispatched; picks the next pending, enabled source
//   REQ     | irq raised; id/vec are committed until ack
//   SERVICE | handler running; waits for eoi
module int_ctrl #(
  parameter int          N          = 4,
  parameter int          ID_W       = 2,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    src_i,
  input  logic            mask_we_i,
  input  logic [N-1:0]    mask_wd_i,
  output logic [N-1:0]    mask_o,
  output logic [N-1:0]    pending_o,
  output logic            irq_o,
  input  logic            ack_i,
  input  logic            eoi_i,
  output logic            busy_o,
  output logic [ID_W-1:0] id_o,
  output logic [31:0]     vec_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    src_q;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    mask_q, mask_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     vec_q, vec_d;

  logic [N-1:0]    src_edge;
  logic [N-1:0]    cand;
  logic [N-1:0]    clr;
  logic [ID_W-1:0] sel_id;

  assign src_edge = src_i & ~src_q;
  assign cand     = pending_q & mask_q;

  // Lowest set index wins, so scan downward and let the last hit stand.
  always_comb begin
    sel_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) sel_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    vec_d   = vec_q;
    clr     = '0;
    mask_d  = mask_we_i ? mask_wd_i : mask_q;
    case (state_q)
      IDLE: begin
        if (|cand) begin
          id_d    = sel_id;
          vec_d   = VEC_BASE + VEC_STRIDE * 32'(sel_id);
          state_d = REQ;
        end
      end
      REQ: begin
        // ack takes priority over a simultaneous eoi; eoi is only looked at in SERVICE.
        if (ack_i) begin
          for (int i = 0; i < N; i++) begin
            clr[i] = (int'(id_q) == i);
          end
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new edge in the same cycle as its acknowledge is kept.
    pending_d = (pending_q & ~clr) | src_edge;
  end

  always_ff @(posedge clk_i) begin
    // src_q follows src even in reset, so a level already high at release is not an event.
    src_q <= src_i;
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      id_q      <= '0;
      vec_q     <= VEC_BASE;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      id_q      <= id_d;
      vec_q     <= vec_d;
    end
  end

  assign mask_o    = mask_q;
  assign pending_o = pending_q;
  assign irq_o     = (state_q == REQ);
  assign busy_o    = (state_q == SERVICE);
  assign id_o      = id_q;
  assign vec_o     = vec_q;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

  localparam int N = 4;
  localparam int ID_W = 2;
  localparam int BASE = 32'h100;
  localparam int STRIDE = 32'h10;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    src = '0;
  logic            mask_we = 1'b0;
  logic [N-1:0]    mask_wd = '0;
  logic [N-1:0]    mask;
  logic [N-1:0]    pending;
  logic            irq;
  logic            ack = 1'b0;
  logic            eoi = 1'b0;
  logic            busy;
  logic [ID_W-1:0] id;
  logic [31:0]     vec;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: phase 0 idle, 1 requesting, 2 in handler
  int m_phase = 0;
  int m_pend  = 0;
  int m_mask  = 0;
  int m_prev  = 0;
  int m_id    = 0;
  int m_vec   = BASE;

  int_ctrl #(.N(N), .ID_W(ID_W), .VEC_BASE(32'h100), .VEC_STRIDE(32'h10)) dut (
    .clk_i(clk), .rst_i(rst), .src_i(src), .mask_we_i(mask_we), .mask_wd_i(mask_wd),
    .mask_o(mask), .pending_o(pending), .irq_o(irq), .ack_i(ack), .eoi_i(eoi),
    .busy_o(busy), .id_o(id), .vec_o(vec)
  );

  always #5 clk = ~clk;

  // highest priority = lowest set bit: isolate it with x & -x, then take its log2
  function automatic int lowest(input int x);
    return $clog2(x & -x);
  endfunction

  task automatic model_edge();
    int rises;
    rises = int'(src) & ~m_prev;
    m_prev = int'(src);
    if (rst) begin
      m_phase = 0; m_pend = 0; m_mask = 0; m_id = 0; m_vec = BASE;
      return;
    end
    if (m_phase == 0 && (m_pend & m_mask) != 0) begin
      m_id = lowest(m_pend & m_mask);
      m_vec = BASE + m_id * STRIDE;
      m_phase = 1;
    end else if (m_phase == 1 && ack) begin
      m_pend = m_pend - (m_pend & (1 << m_id));
      m_phase = 2;
    end else if (m_phase == 2 && eoi) begin
      m_phase = 0;
    end
    m_pend = m_pend | rises;
    if (mask_we) m_mask = int'(mask_wd);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic write_mask(input logic [N-1:0] v);
    mask_we = 1'b1; mask_wd = v;
    step();
    mask_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; src = '0;
    step(); step();
    rst = 1'b0;
    step();
    n_checks++;
    if ({irq, busy} !== 2'b00) $display("FAIL reset_irq_busy: got %b expected 00", {irq, busy});
    else n_pass++;
    n_checks++;
    if (id !== 2'd0 || vec !== 32'h100) $display("FAIL reset_id_vec: got %0d/%h expected 0/100", id, vec);
    else n_pass++;
    n_checks++;
    if (pending !== 4'b0 || mask !== 4'b0) $display("FAIL reset_pend_mask: got %b/%b expected 0000/0000", pending, mask);
    else n_pass++;
  endtask

  task automatic test_basic();
    write_mask(4'b1111);
    src = 4'b0100; step(); src = '0;
    n_checks++;
    if (pending !== 4'b0100 || irq !== 1'b0) $display("FAIL basic_latch: got pend=%b irq=%b expected 0100/0", pending, irq);
    else n_pass++;
    step();
    n_checks++;
    if (irq !== 1'b1 || id !== 2'd2 || vec !== 32'h120) $display("FAIL basic_req: got irq=%b id=%0d vec=%h expected 1/2/120", irq, id, vec);
    else n_pass++;
    ack = 1'b1; step(); ack = 1'b0;
    n_checks++;
    if (irq !== 1'b0 || busy !== 1'b1 || pending !== 4'b0) $display("FAIL basic_ack: got irq=%b busy=%b pend=%b expected 0/1/0000", irq, busy, pending);
    else n_pass++;
    eoi = 1'b1; step(); eoi = 1'b0;
    n_checks++;
    if (irq !== 1'b0 || busy !== 1'b0) $display("FAIL basic_eoi: got irq=%b busy=%b expected 0/0", irq, busy);
    else n_pass++;
  endtask

  task automatic test_priority();
    src = 4'b1010; step(); src = '0;
    step();
    n_checks++;
    if (irq !== 1'b1 || id !== 2'd1 || vec !== 32'h110) $display("FAIL prio_first: got irq=%b id=%0d vec=%h expected 1/1/110", irq, id, vec);
    else n_pass++;
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    n_checks++;
    if (irq !== 1'b0 || busy !== 1'b0) $display("FAIL prio_gap: got irq=%b busy=%b expected 0/0", irq, busy);
    else n_pass++;
    step();
    n_checks++;
    if (irq !== 1'b1 || id !== 2'd3 || vec !== 32'h130) $display("FAIL prio_second: got irq=%b id=%0d vec=%h expected 1/3/130", irq, id, vec);
    else n_pass++;
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  task automatic test_mask();
    write_mask(4'b0000);
    src = 4'b0001; step(); src = '0;
    step(); step();
    n_checks++;
    if (pending !== 4'b0001 || irq !== 1'b0) $display("FAIL mask_hold: got pend=%b irq=%b expected 0001/0", pending, irq);
    else n_pass++;
    write_mask(4'b0001);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL mask_write_edge: got irq=%b expected 0", irq);
    else n_pass++;
    step();
    n_checks++;
    if (irq !== 1'b1 || id !== 2'd0 || vec !== 32'h100) $display("FAIL mask_dispatch: got irq=%b id=%0d vec=%h expected 1/0/100", irq, id, vec);
    else n_pass++;
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  task automatic test_committed();
    write_mask(4'b1111);
    src = 4'b0100; step(); src = '0;
    step();
    src = 4'b0001; mask_we = 1'b1; mask_wd = 4'b1011;
    step();
    src = '0; mask_we = 1'b0;
    n_checks++;
    if (irq !== 1'b1 || id !== 2'd2 || vec !== 32'h120) $display("FAIL commit_hold: got irq=%b id=%0d vec=%h expected 1/2/120", irq, id, vec);
    else n_pass++;
    step();
    n_checks++;
    if (irq !== 1'b1 || id !== 2'd2) $display("FAIL commit_hold2: got irq=%b id=%0d expected 1/2", irq, id);
    else n_pass++;
    ack = 1'b1; src = 4'b0100; step(); ack = 1'b0; src = '0;
    n_checks++;
    if (pending !== 4'b0101 || busy !== 1'b1) $display("FAIL commit_reraise: got pend=%b busy=%b expected 0101/1", pending, busy);
    else n_pass++;
    eoi = 1'b1; step(); eoi = 1'b0;
    step();
    n_checks++;
    if (irq !== 1'b1 || id !== 2'd0) $display("FAIL commit_next: got irq=%b id=%0d expected 1/0", irq, id);
    else n_pass++;
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  task automatic test_reset_paths();
    rst = 1'b1; src = 4'b0010;
    step(); step();
    rst = 1'b0;
    step();
    n_checks++;
    if (pending !== 4'b0000) $display("FAIL reset_held_src: got pend=%b expected 0000", pending);
    else n_pass++;
    write_mask(4'b1111);
    src = 4'b0011; step();
    step();
    ack = 1'b1; step(); ack = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL reset_reach_service: got busy=%b expected 1", busy);
    else n_pass++;
    rst = 1'b1; step(); rst = 1'b0;
    n_checks++;
    if (irq !== 1'b0 || busy !== 1'b0 || pending !== 4'b0 || mask !== 4'b0 || vec !== 32'h100)
      $display("FAIL reset_in_service: got irq=%b busy=%b pend=%b mask=%b vec=%h expected 0/0/0000/0000/100",
               irq, busy, pending, mask, vec);
    else n_pass++;
    ack = 1'b1; eoi = 1'b1; step(); ack = 1'b0; eoi = 1'b0;
    n_checks++;
    if (irq !== 1'b0 || busy !== 1'b0 || id !== 2'd0 || pending !== 4'b0) $display("FAIL stray_ack_eoi: got irq=%b busy=%b id=%0d pend=%b expected 0/0/0/0000", irq, busy, id, pending);
    else n_pass++;
    src = '0; step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      src     = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      ack     = ($urandom_range(0, 3) == 0);
      eoi     = ($urandom_range(0, 3) == 0);
      mask_we = ($urandom_range(0, 15) == 0);
      mask_wd = 4'($urandom_range(0, 15));
      rst     = ($urandom_range(0, 199) == 0);
      step();
      n_checks++;
      if (irq !== (m_phase == 1) || busy !== (m_phase == 2) || int'(id) != m_id || vec !== 32'(m_vec)
          || int'(pending) != m_pend || int'(mask) != m_mask)
        $display("FAIL random_cycle_%0d: got irq=%b busy=%b id=%0d vec=%h pend=%b mask=%b expected phase=%0d id=%0d vec=%h pend=%h mask=%h",
                 c, irq, busy, id, vec, pending, mask, m_phase, m_id, m_vec, m_pend, m_mask);
      else n_pass++;
    end
    src = '0; ack = 1'b0; eoi = 1'b0; mask_we = 1'b0; rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_committed();
    test_reset_paths();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller for the CPU's external interrupt line. It edge-detects and latches up to N interrupt sources into a pending register, masks them with a software-writable enable register and picks the highest-priority pending source. It then runs a request/acknowledge/end-of-interrupt handshake with the CPU and presents the handler vector. It sits between the peripheral interrupt outputs and the CPU's interrupt input/exception logic.

## Interface
- N, 4: number of interrupt sources (1..16); source 0 has highest priority.
- ID_W, 2: width of source index; must be ≥ clog2(N), minimum 1.
- VEC_BASE, 32'h0000_0100: vector address of source 0.
- VEC_STRIDE, 32'h0000_0010: byte spacing between consecutive source vectors.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- src  in  N  raw interrupt sources, level in, rising edge = event; synchronous to clk.
- mask_we  in  1  write strobe for mask register.
- mask_wd  in  N  mask write data; 1 = source enabled.
- mask  out  N  current mask register.
- pending  out  N  latched, not-yet-acknowledged events.
- irq  out  1  interrupt request to CPU.
- ack  in  1  CPU accepts the request (single-cycle pulse).
- eoi  in  1  CPU finished the handler (single-cycle pulse).
- busy  out  1  handler in progress (SERVICE state).
- id  out  ID_W  index of the dispatched source.
- vec  out  32  VEC_BASE + id*VEC_STRIDE, modulo 2^32.

## Operation
- Edge detect: src_q <= src every cycle; edge[i] = src[i] & ~src_q[i].
- Pending: pending[i] set on edge[i], independent of mask; cleared only when source i is acknowledged. Same-cycle set and clear of one bit: set wins, so the new event is kept.
- Mask: mask <= mask_wd on mask_we; affects dispatch only, never pending.
- Selection: lowest index i with pending[i] & mask[i].
- FSM states:
  - IDLE: irq=0, busy=0. If any pending & mask: latch id = selection, go to REQ.
  - REQ: irq=1, id and vec held stable. On ack: clear pending[id], go to SERVICE. Masking or a higher-priority arrival while in REQ does not change id; the request is committed.
  - SERVICE: irq=0, busy=1. On eoi: go to IDLE. There is no nesting; new events only accumulate in pending.
- ack outside REQ and eoi outside SERVICE are ignored. ack and eoi in the same cycle in REQ: only ack takes effect.
- Reset: state=IDLE; irq=0, busy=0, id=0, vec=VEC_BASE, pending=0, mask=0. src_q <= src during reset, so a source already high at reset release produces no event.
- id and vec are registered and hold their last value in IDLE and SERVICE.

## Timing
- src[i] rises and is sampled at edge k: pending[i]=1 after edge k.
- If enabled and in IDLE: state=REQ after edge k+1, so irq asserts 2 cycles after the source event.
- ack sampled at edge m in REQ: after edge m, irq=0, busy=1, pending[id]=0.
- eoi sampled at edge e: IDLE after e. The next dispatch is at e+1, with irq visible after e+1 (minimum 1-cycle irq gap).
- mask write at edge w takes effect for selection at edge w+1.
- A source held high generates exactly one event. A new event requires src low for ≥1 sampled cycle.
- rst asserted in any state: all outputs take reset values after that edge. Pending events are discarded.

## Test plan
- N=4, mask=4'b1111; pulse src[2]: irq=1 two cycles later, id=2, vec=0x120. ack gives irq=0, busy=1, pending=0. eoi gives IDLE.
- Raise src[3] and src[1] in the same cycle: dispatch id=1 (vec=0x110). After ack/eoi, dispatch id=3 (vec=0x130) with exactly 1 idle cycle between irq pulses.
- mask=0; pulse src[0]: pending=4'b0001, irq stays 0. Write mask=4'b0001: irq asserts the cycle after the write, id=0.
- In REQ with id=2, raise src[0] and clear mask[2]: id stays 2 until ack. After eoi, id=0 is dispatched. Re-pulse src[2] in the same cycle as ack: pending[2] stays 1.
- Hold src[1] high across reset release: no pending. Then in SERVICE, assert rst: irq=0, busy=0, pending=0, mask=0, vec=0x100 next cycle. Stray ack/eoi while in IDLE cause no change.
